// File: rtl/scanline_fx_if.sv
// rtl/scanline_fx_if.sv - video bus between the scandoubler, scanline_fx and the mixer.
// master drives the incoming pixel stream; slave is the scanline_fx side.
interface scanline_fx_if #(
  parameter int DW = 6
);
  logic [1:0]    scanlines;
  logic          ce_pix;
  logic          hs_in;
  logic          vs_in;
  logic          hb_in;
  logic          vb_in;
  logic [DW-1:0] r_in;
  logic [DW-1:0] g_in;
  logic [DW-1:0] b_in;

  logic          ce_pix_out;
  logic          hs_out;
  logic          vs_out;
  logic          hb_out;
  logic          vb_out;
  logic [DW-1:0] r_out;
  logic [DW-1:0] g_out;
  logic [DW-1:0] b_out;
  logic          line_odd;

  modport master (
    output scanlines, ce_pix, hs_in, vs_in, hb_in, vb_in, r_in, g_in, b_in,
    input  ce_pix_out, hs_out, vs_out, hb_out, vb_out, r_out, g_out, b_out, line_odd
  );

  modport slave (
    input  scanlines, ce_pix, hs_in, vs_in, hb_in, vb_in, r_in, g_in, b_in,
    output ce_pix_out, hs_out, vs_out, hb_out, vb_out, r_out, g_out, b_out, line_odd
  );
endinterface

// File: rtl/scanline_fx.sv
// rtl/scanline_fx.sv - CRT scanline dimming of odd lines after the scandoubler.
// Two ce_pix-gated pipeline stages; line parity and mode follow sync edges every clock.
module scanline_fx #(
  parameter int HALF_DEPTH = 0
) (
  input  logic           clk_vid,
  input  logic           reset_n,
  scanline_fx_if.slave   vid
);
  localparam int DW = (HALF_DEPTH != 0) ? 4 : 6;

  logic          hs_d_q, vs_d_q;
  logic          parity_q, parity_d;
  logic [1:0]    mode_q, mode_d;
  logic          vs_rise, hs_rise;
  logic          ce_q;

  logic [DW-1:0] r1_q, g1_q, b1_q;
  logic          hs1_q, vs1_q, hb1_q, vb1_q, dim1_q, blank1_q;
  logic [DW-1:0] r2_q, g2_q, b2_q;
  logic          hs2_q, vs2_q, hb2_q, vb2_q;

  // vsync takes precedence so a line starting on the frame edge is always even
  always_comb begin
    vs_rise  = vid.vs_in & ~vs_d_q;
    hs_rise  = vid.hs_in & ~hs_d_q;
    parity_d = parity_q;
    mode_d   = mode_q;
    if (vs_rise) begin
      parity_d = 1'b0;
      mode_d   = vid.scanlines;
    end else if (hs_rise) begin
      parity_d = ~parity_q;
    end
  end

  function automatic logic [DW-1:0] shade(
    input logic [DW-1:0] x,
    input logic          blank,
    input logic          dim,
    input logic [1:0]    mode
  );
    logic [DW-1:0] y;
    if (blank) begin
      y = '0;
    end else if (!dim) begin
      y = x;
    end else begin
      case (mode)
        2'd1:    y = (x >> 1) + (x >> 2);
        2'd2:    y = x >> 1;
        2'd3:    y = x >> 2;
        default: y = x;
      endcase
    end
    return y;
  endfunction

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      hs_d_q   <= 1'b0;
      vs_d_q   <= 1'b0;
      parity_q <= 1'b0;
      mode_q   <= 2'd0;
      ce_q     <= 1'b0;
      r1_q     <= '0;
      g1_q     <= '0;
      b1_q     <= '0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      hb1_q    <= 1'b0;
      vb1_q    <= 1'b0;
      dim1_q   <= 1'b0;
      blank1_q <= 1'b0;
      r2_q     <= '0;
      g2_q     <= '0;
      b2_q     <= '0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      hb2_q    <= 1'b0;
      vb2_q    <= 1'b0;
    end else begin
      hs_d_q   <= vid.hs_in;
      vs_d_q   <= vid.vs_in;
      parity_q <= parity_d;
      mode_q   <= mode_d;
      ce_q     <= vid.ce_pix;
      if (vid.ce_pix) begin
        r1_q     <= vid.r_in;
        g1_q     <= vid.g_in;
        b1_q     <= vid.b_in;
        hs1_q    <= vid.hs_in;
        vs1_q    <= vid.vs_in;
        hb1_q    <= vid.hb_in;
        vb1_q    <= vid.vb_in;
        dim1_q   <= parity_q & (mode_q != 2'd0);
        blank1_q <= vid.hb_in | vid.vb_in;
        r2_q     <= shade(r1_q, blank1_q, dim1_q, mode_q);
        g2_q     <= shade(g1_q, blank1_q, dim1_q, mode_q);
        b2_q     <= shade(b1_q, blank1_q, dim1_q, mode_q);
        hs2_q    <= hs1_q;
        vs2_q    <= vs1_q;
        hb2_q    <= hb1_q;
        vb2_q    <= vb1_q;
      end
    end
  end

  assign vid.ce_pix_out = ce_q;
  assign vid.hs_out     = hs2_q;
  assign vid.vs_out     = vs2_q;
  assign vid.hb_out     = hb2_q;
  assign vid.vb_out     = vb2_q;
  assign vid.r_out      = r2_q;
  assign vid.g_out      = g2_q;
  assign vid.b_out      = b2_q;
  assign vid.line_odd   = parity_q;
endmodule

// File: tb/tb_scanline_fx.sv
// tb/tb_scanline_fx.sv - bench for scanline_fx, 6-bit and 4-bit instances on shared stimulus.
// A queue-based model predicts every output each cycle; directed literals pin the model.
module tb_scanline_fx;
  logic clk_vid = 1'b0;
  logic reset_n;
  always #5 clk_vid = ~clk_vid;

  scanline_fx_if #(.DW(6)) v6 ();
  scanline_fx_if #(.DW(4)) v4 ();

  scanline_fx #(.HALF_DEPTH(0)) dut6 (.clk_vid(clk_vid), .reset_n(reset_n), .vid(v6));
  scanline_fx #(.HALF_DEPTH(1)) dut4 (.clk_vid(clk_vid), .reset_n(reset_n), .vid(v4));

  logic [1:0] scan;
  logic       ce, hs, vs, hb, vb;
  logic [5:0] c6;
  logic [3:0] c4;

  assign v6.scanlines = scan;  assign v4.scanlines = scan;
  assign v6.ce_pix = ce;       assign v4.ce_pix = ce;
  assign v6.hs_in = hs;        assign v4.hs_in = hs;
  assign v6.vs_in = vs;        assign v4.vs_in = vs;
  assign v6.hb_in = hb;        assign v4.hb_in = hb;
  assign v6.vb_in = vb;        assign v4.vb_in = vb;
  assign v6.r_in = c6;  assign v6.g_in = c6 ^ 6'h15;  assign v6.b_in = ~c6;
  assign v4.r_in = c4;  assign v4.g_in = c4 ^ 4'h5;   assign v4.b_in = ~c4;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int r6, g6, b6, r4, g4, b4;
    bit hs, vs, hb, vb, dim, blank;
  } pix_t;

  pix_t pix_q[$];
  pix_t e;
  pix_t zero_pix;
  bit   m_ce, m_par, m_hs, m_vs;
  int   m_mode;
  int   o_r6, o_g6, o_b6, o_r4, o_g4, o_b4;

  function automatic int att(int x, int mode, bit dim, bit blank);
    if (blank) return 0;
    if (!dim) return x;
    case (mode)
      1: return x / 2 + x / 4;
      2: return x / 2;
      3: return x / 4;
      default: return x;
    endcase
  endfunction

  initial zero_pix = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  always @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      m_ce = 0; m_par = 0; m_mode = 0; m_hs = 0; m_vs = 0;
      pix_q.delete();
      pix_q.push_back(zero_pix);
      e = zero_pix;
      o_r6 = 0; o_g6 = 0; o_b6 = 0; o_r4 = 0; o_g4 = 0; o_b4 = 0;
    end else begin
      pix_t p;
      m_ce = ce;
      if (ce) begin
        p.r6 = c6; p.g6 = c6 ^ 6'h15; p.b6 = 6'(~c6);
        p.r4 = c4; p.g4 = c4 ^ 4'h5;  p.b4 = 4'(~c4);
        p.hs = hs; p.vs = vs; p.hb = hb; p.vb = vb;
        p.dim = m_par && (m_mode != 0);
        p.blank = hb || vb;
        pix_q.push_back(p);
        e = pix_q.pop_front();
        o_r6 = att(e.r6, m_mode, e.dim, e.blank);
        o_g6 = att(e.g6, m_mode, e.dim, e.blank);
        o_b6 = att(e.b6, m_mode, e.dim, e.blank);
        o_r4 = att(e.r4, m_mode, e.dim, e.blank);
        o_g4 = att(e.g4, m_mode, e.dim, e.blank);
        o_b4 = att(e.b4, m_mode, e.dim, e.blank);
      end
      if (vs && !m_vs) begin
        m_par = 0;
        m_mode = scan;
      end else if (hs && !m_hs) begin
        m_par = !m_par;
      end
      m_hs = hs;
      m_vs = vs;
    end
  end

  always @(posedge clk_vid) begin
    #2;
    if (chk_en) begin
      chk("cyc6",
          {v6.ce_pix_out, v6.line_odd, v6.hs_out, v6.vs_out, v6.hb_out, v6.vb_out,
           v6.r_out, v6.g_out, v6.b_out},
          {m_ce, m_par, e.hs, e.vs, e.hb, e.vb, 6'(o_r6), 6'(o_g6), 6'(o_b6)});
      chk("cyc4",
          {v4.ce_pix_out, v4.line_odd, v4.hs_out, v4.vs_out, v4.hb_out, v4.vb_out,
           v4.r_out, v4.g_out, v4.b_out},
          {m_ce, m_par, e.hs, e.vs, e.hb, e.vb, 4'(o_r4), 4'(o_g4), 4'(o_b4)});
    end
  end

  task automatic step();
    @(negedge clk_vid);
  endtask

  task automatic vs_frame();
    ce = 1; vs = 1; vb = 1; hb = 1;
    repeat (3) step();
    vs = 0;
    step();
    vb = 0; hb = 0;
  endtask

  task automatic do_line(input logic [5:0] col6, input logic [3:0] col4, input bit alt);
    ce = 1; hs = 1; hb = 1;
    step(); step();
    hs = 0;
    step();
    hb = 0; c6 = col6; c4 = col4;
    for (int i = 0; i < 6; i++) begin
      ce = alt ? (i % 2 == 0) : 1'b1;
      step();
    end
    ce = 1;
  endtask

  task automatic lit_line(input string name, input bit odd, input logic [5:0] r6, input logic [3:0] r4);
    chk({name, "_odd"}, 64'(v6.line_odd), 64'(odd));
    chk({name, "_r6"}, 64'(v6.r_out), 64'(r6));
    chk({name, "_r4"}, 64'(v4.r_out), 64'(r4));
  endtask

  initial begin
    reset_n = 0; scan = 2'd2; ce = 1; hs = 0; vs = 0; hb = 0; vb = 0;
    c6 = 6'h3F; c4 = 4'hF;
    chk_en = 1;
    step();
    hs = 1; step(); hs = 0; step();
    chk("rst_ce", 64'(v6.ce_pix_out), 64'd0);
    lit_line("rst", 1'b0, 6'h00, 4'h0);

    reset_n = 1; c6 = 6'h12; c4 = 4'h3; scan = 2'd0;
    step();
    c6 = 6'h34; c4 = 4'h9;
    step();
    lit_line("lat2", 1'b0, 6'h12, 4'h3);
    step();
    lit_line("lat2b", 1'b0, 6'h34, 4'h9);

    scan = 2'd2; vs_frame();
    do_line(6'h3F, 4'hF, 0); lit_line("m2_l1", 1'b1, 6'h1F, 4'h7);
    do_line(6'h3F, 4'hF, 1); lit_line("m2_l2", 1'b0, 6'h3F, 4'hF);
    do_line(6'h3F, 4'hF, 1); lit_line("m2_l3", 1'b1, 6'h1F, 4'h7);

    scan = 2'd1; vs_frame();
    do_line(6'h3F, 4'hF, 0); lit_line("m1", 1'b1, 6'h2E, 4'hA);
    scan = 2'd3; vs_frame();
    do_line(6'h3F, 4'hF, 0); lit_line("m3", 1'b1, 6'h0F, 4'h3);

    scan = 2'd2; vs_frame();
    do_line(6'h3F, 4'hF, 0);
    scan = 2'd3;
    do_line(6'h3F, 4'hF, 0); lit_line("mid_even", 1'b0, 6'h3F, 4'hF);
    do_line(6'h3F, 4'hF, 0); lit_line("mid_odd", 1'b1, 6'h1F, 4'h7);
    vs_frame();
    do_line(6'h3F, 4'hF, 0); lit_line("next_fr", 1'b1, 6'h0F, 4'h3);

    hb = 1; step();
    lit_line("hb_d1", 1'b1, 6'h0F, 4'h3);
    hb = 0; step();
    lit_line("hb_d2", 1'b1, 6'h00, 4'h0);
    chk("hb_out_d2", 64'(v6.hb_out), 64'd1);
    step();
    lit_line("hb_d3", 1'b1, 6'h0F, 4'h3);
    chk("hb_out_d3", 64'(v6.hb_out), 64'd0);

    vs = 1; hs = 1; step();
    vs = 0; hs = 0; step();
    chk("vs_hs_same", 64'(v6.line_odd), 64'd0);
    do_line(6'h3F, 4'hF, 0); lit_line("after_same", 1'b1, 6'h0F, 4'h3);

    reset_n = 0; step();
    lit_line("rst_mid", 1'b0, 6'h00, 4'h0);
    chk("rst_mid_ce", 64'(v6.ce_pix_out), 64'd0);
    reset_n = 1;
    repeat (3) step();
    lit_line("post_rst", 1'b0, 6'h3F, 4'hF);
    do_line(6'h3F, 4'hF, 0); lit_line("post_rst_odd", 1'b1, 6'h3F, 4'hF);
    vs_frame();
    do_line(6'h2A, 4'h6, 1); lit_line("re_dim", 1'b1, 6'h0A, 4'h1);
    repeat (3) step();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
